// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size codes, FSM encoding and alignment helper for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10,
        S_RESP  = 2'b11
    } lsu_state_t;

    // Size code 2'b11 is treated as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        if (size == SZ_BYTE) return 1'b0;
        if (size == SZ_HALF) return offset[0];
        return offset != 2'b00;
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// rtl/lsu_lane_merge.sv - combinational lane extraction/extension for loads and lane merge for stores
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] merged,
    output logic [31:0] loaded
);

    logic [1:0]  lane;
    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] shifted;

    always_comb begin
        lane  = 2'b00;
        mask  = 32'hFFFF_FFFF;
        // Halves drop addr[0] and words drop addr[1:0]: forced alignment.
        case (size)
            SZ_BYTE: begin
                lane = offset;
                mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                lane = {offset[1], 1'b0};
                mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
        shamt   = {lane, 3'b000};
        shifted = word >> shamt;
        case (size)
            SZ_BYTE: loaded = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SZ_HALF: loaded = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: loaded = word;
        endcase
        merged = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store FSM over a word-wide memory; MISALIGN_TRAP_EN enables misalignment trap
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wrEn,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state;
    logic              we_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rd_q;
    logic [31:0]       lane_word;
    logic [31:0]       merged;
    logic [31:0]       loaded;

    // Strobes decode straight from the state register so they cannot glitch on req_* changes.
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign mem_wrEn   = (state == S_WRITE);
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = merged;
    assign lane_word  = (state == S_READ) ? mem_rdata : rd_q;

    lsu_lane_merge u_lane_merge (
        .word      (lane_word),
        .wdata     (wdata_q),
        .offset    (addr_q[1:0]),
        .size      (size_q),
        .is_signed (signed_q),
        .merged    (merged),
        .loaded    (loaded)
    );

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rd_q       <= 32'h0;
            resp_rdata <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        signed_q   <= req_signed;
                        size_q     <= req_size;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        resp_rdata <= 32'h0;
`ifdef MISALIGN_TRAP_EN
                        err_q      <= is_misaligned(req_size, req_addr[1:0]);
                        state      <= is_misaligned(req_size, req_addr[1:0]) ? S_RESP : S_READ;
`else
                        state      <= S_READ;
`endif
                    end
                end
                S_READ: begin
                    rd_q <= mem_rdata;
                    if (we_q) begin
                        state <= S_WRITE;
                    end else begin
                        resp_rdata <= loaded;
                        state      <= S_RESP;
                    end
                end
                S_WRITE: state <= S_RESP;
                S_RESP: begin
                    if (resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with byte-array reference model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_wrEn;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wrEn   (mem_wrEn),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Word-wide data memory (16 words) with a preload port
    logic [31:0] mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_val = 32'h0;
    int          wr_count = 0;

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (mem_wrEn) begin
            mem[mem_addr[5:2]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    // Reference model: memory as a flat little-endian byte array
    logic [7:0] ref_mem [64];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic we, input logic [1:0] size, input logic sgn,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t   r;
        int     a;
        int     nb;
        longint v;
        a  = int'(addr[5:0]);
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        r.rdata = 32'h0;
        r.err   = 1'b0;
        r.wr    = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if ((a % nb) != 0) begin
            r.err = 1'b1;
            return r;
        end
`endif
        a = a - (a % nb);
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[a + i] = wdata[8*i +: 8];
            r.wr = 1'b1;
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v + (longint'(ref_mem[a + i]) << (8 * i));
            if (sgn && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
            r.rdata = v[31:0];
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard on every response handshake
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL resp_unexpected actual=%h expected=none", resp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, mon_e.rdata);
                check("resp_err", 32'(resp_err), 32'(mon_e.err));
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = 4'(idx);
        pl_val = val;
        for (int i = 0; i < 4; i++) ref_mem[4*idx + i] = val[8*i +: 8];
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, output logic [31:0] got);
        exp_t        e;
        int          lat;
        int          wr0;
        int          wr_at;
        int          exp_lat;
        logic [31:0] held;
        e = model(we, size, sgn, addr, wdata);
        exp_q.push_back(e);
        exp_lat = e.err ? 1 : (we ? 3 : 2);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        wr0   = wr_count;
        lat   = 1;
        wr_at = 0;
        while (!resp_valid && lat < 10) begin
            req_addr  = $urandom_range(0, 63);
            req_wdata = $urandom;
            req_size  = 2'($urandom_range(0, 3));
            req_we    = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
            if (mem_wrEn) wr_at = (wr_at == 0) ? lat : -1;
        end
        if (!resp_valid) begin
            $display("FAIL resp_timeout actual=no_resp expected=resp_valid");
            $fatal(1);
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("wr_cycle", 32'(wr_at), e.wr ? 32'd2 : 32'd0);
        held = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_addr  = $urandom_range(0, 63);
            @(posedge clk);
            #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, held);
            check("hold_no_accept", 32'(req_ready), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        got        = resp_rdata;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("resp_done", 32'(resp_valid), 32'd0);
        check("wr_count", 32'(wr_count - wr0), e.wr ? 32'd1 : 32'd0);
    endtask

    logic [31:0] got;
    logic [31:0] word;

    initial begin
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_wren", 32'(mem_wrEn), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        preload(1, 32'h8899AABB);
        do_op(1'b0, 2'b00, 1'b1, 32'd4, 32'h0, 0, got);
        check("t1_lb_signed", got, 32'hFFFFFFBB);
        do_op(1'b0, 2'b00, 1'b0, 32'd6, 32'h0, 0, got);
        check("t1_lb_unsigned", got, 32'h00000099);
        do_op(1'b0, 2'b01, 1'b1, 32'd6, 32'h0, 0, got);
        check("t2_lh_signed", got, 32'hFFFF8899);
        do_op(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 0, got);
        check("t2_lw", got, 32'h8899AABB);

        preload(2, 32'h11223344);
        do_op(1'b1, 2'b00, 1'b0, 32'd9, 32'h000000EE, 0, got);
        check("t3_sb", mem[2], 32'h1122EE44);
        check("t3_store_rdata", got, 32'h0);
        preload(2, 32'h11223344);
        do_op(1'b1, 2'b01, 1'b0, 32'd10, 32'h0000CAFE, 0, got);
        check("t4_sh", mem[2], 32'hCAFE3344);
        do_op(1'b1, 2'b10, 1'b0, 32'd8, 32'hFFFFFFFF, 0, got);
        check("t4_sw", mem[2], 32'hFFFFFFFF);

        do_op(1'b0, 2'b01, 1'b0, 32'd4, 32'h0, 5, got);
        check("t5_hold_lh", got, 32'h0000AABB);

        // Reset while the store sits in WRITE: the strobe must fall immediately
        word = mem[3];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'd13; req_wdata = 32'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check("t5_in_write", 32'(mem_wrEn), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_wren", 32'(mem_wrEn), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd1);
        check("t5_rst_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_abandoned", mem[3], word);

        do_op(1'b0, 2'b10, 1'b0, 32'd6, 32'h0, 0, got);
`ifdef MISALIGN_TRAP_EN
        check("t6_misaligned_lw", got, 32'h0);
`else
        check("t6_misaligned_lw", got, 32'h8899AABB);
`endif

        for (int n = 0; n < 300; n++) begin
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2), got);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check("final_mem", mem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
